// File: rtl/rs_syndrome_calc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : rs_syndrome_calc
// Brief    : Streaming Reed-Solomon syndrome generator over GF(2^8)
//            (poly 0x11D, alpha = 0x02, roots alpha^1..alpha^16). Takes one
//            symbol per clock and hands a packed 128-bit syndrome vector to
//            a Berlekamp-Massey decoder. One result is held while the next
//            codeword accumulates.
// Revision : 1.0 - initial release
// ============================================================================
module rs_syndrome_calc #(
  parameter int N_SYM = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   sym_in,
  input  logic         sym_valid,
  input  logic         sym_last,
  output logic         sym_ready,
  input  logic         ds_busy,
  output logic [127:0] syn_out,
  output logic         syn_valid,
  output logic         syn_nonzero,
  output logic         frame_err
);

  localparam int CNT_W = $clog2(N_SYM);
  localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(N_SYM - 1);

  // Multiply by alpha^pw. Unrolled with a constant pw this is a pure XOR
  // network: each step is a left shift with conditional reduction by 0x1D.
  function automatic logic [7:0] gf_mul_alpha_pow(input logic [7:0] x, input int pw);
    logic [7:0] v;
    v = x;
    for (int i = 0; i < pw; i++) begin
      v = {v[6:0], 1'b0} ^ (v[7] ? 8'h1D : 8'h00);
    end
    return v;
  endfunction

  logic [CNT_W-1:0]  r_cnt;
  logic              r_pending;
  logic [15:0][7:0]  r_acc;
  logic [127:0]      r_syn_out;
  logic              r_syn_valid;
  logic              r_syn_nonzero;
  logic              r_frame_err;

  logic [15:0][7:0]  w_acc_next;
  logic              w_accept;
  logic              w_at_last;
  logic              w_final;
  logic              w_ferr;
  logic              w_emit;

  // Ready depends only on registered state, never on sym_valid.
  assign sym_ready = !(r_pending && w_at_last);

  assign w_accept  = sym_valid && sym_ready;
  assign w_at_last = (r_cnt == c_last_idx);
  assign w_final   = w_accept && w_at_last && sym_last;
  assign w_ferr    = w_accept && (sym_last != w_at_last);
  assign w_emit    = r_pending && !ds_busy && !r_syn_valid;

  // Horner step for all 16 syndromes; the first symbol of a frame seeds them.
  always_comb begin
    w_acc_next = '0;
    for (int j = 0; j < 16; j++) begin
      w_acc_next[j] = ((r_cnt == '0) ? 8'h00 : gf_mul_alpha_pow(r_acc[j], j + 1)) ^ sym_in;
    end
  end

  // Accumulators advance on every accepted symbol.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (w_accept) begin
      r_acc <= w_acc_next;
    end
  end

  // Symbol index; wraps on the last index and restarts on a framing error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      if (w_at_last || w_ferr) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Result capture, pending flag and the one-cycle downstream handshake.
  // A final load cannot coincide with an emit: the final symbol is only
  // accepted while nothing is pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_syn_out     <= '0;
      r_syn_nonzero <= 1'b0;
      r_pending     <= 1'b0;
      r_syn_valid   <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_syn_valid <= w_emit;
      r_frame_err <= w_ferr;
      if (w_final) begin
        r_syn_out     <= w_acc_next;
        r_syn_nonzero <= |w_acc_next;
        r_pending     <= 1'b1;
      end else if (w_emit) begin
        r_pending     <= 1'b0;
      end
    end
  end

  assign syn_out     = r_syn_out;
  assign syn_valid   = r_syn_valid;
  assign syn_nonzero = r_syn_nonzero;
  assign frame_err   = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_rs_syndrome_calc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_rs_syndrome_calc
// Brief    : Directed self-checking bench for rs_syndrome_calc (N_SYM=255).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rs_syndrome_calc;

  localparam int N = 255;

  // Hand-computed syndrome vectors (S16 in the top byte, S1 in the bottom).
  localparam logic [127:0] c_zero  = 128'h0;
  localparam logic [127:0] c_deg0  = 128'h0505_0505_0505_0505_0505_0505_0505_0505;
  localparam logic [127:0] c_deg1  = 128'h4C26_1387_CDE8_743A_1D80_4020_1008_0402;
  localparam logic [127:0] c_d1d0  = 128'h4923_1682_C8ED_713F_1885_4525_150D_0107;
  localparam logic [127:0] c_deg2  = 128'h9D60_1806_8FEA_B42D_4C13_CD74_1D40_1004;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   sym_in;
  logic         sym_valid;
  logic         sym_last;
  logic         sym_ready;
  logic         ds_busy;
  logic [127:0] syn_out;
  logic         syn_valid;
  logic         syn_nonzero;
  logic         frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  int vc;

  rs_syndrome_calc #(.N_SYM(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .sym_in      (sym_in),
    .sym_valid   (sym_valid),
    .sym_last    (sym_last),
    .sym_ready   (sym_ready),
    .ds_busy     (ds_busy),
    .syn_out     (syn_out),
    .syn_valid   (syn_valid),
    .syn_nonzero (syn_nonzero),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  // Count output pulses away from the active edge.
  always @(negedge clk) begin
    if (syn_valid) valid_cnt <= valid_cnt + 1;
    if (frame_err) ferr_cnt  <= ferr_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one symbol and hold it until accepted; returns 1ns after the edge.
  task automatic send_sym(input logic [7:0] d, input logic last);
    int guard;
    guard = 0;
    sym_in = d;
    sym_valid = 1'b1;
    sym_last = last;
    @(negedge clk);
    while (!sym_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) check("ready_timeout", {127'd0, sym_ready}, 128'd1);
    @(posedge clk);
    #1;
    sym_valid = 1'b0;
    sym_last = 1'b0;
    sym_in = 8'h00;
  endtask

  // All-zero codeword except up to two positions (index -1 means unused).
  task automatic send_cw(input int pa, input logic [7:0] va, input int pb, input logic [7:0] vb);
    for (int i = 0; i < N; i++) begin
      send_sym((i == pa) ? va : ((i == pb) ? vb : 8'h00), i == N - 1);
    end
  endtask

  // Called right after the final symbol's edge with ds_busy low.
  task automatic expect_result(input string tag, input logic [127:0] exp, input logic exp_nz);
    check({tag, "_valid_early"}, {127'd0, syn_valid}, 128'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, {127'd0, syn_valid}, 128'd1);
    check({tag, "_syn"}, syn_out, exp);
    check({tag, "_nz"}, {127'd0, syn_nonzero}, {127'd0, exp_nz});
    @(posedge clk); #1;
    check({tag, "_valid_pulse"}, {127'd0, syn_valid}, 128'd0);
  endtask

  initial begin
    rst = 1'b1; sym_in = 8'h00; sym_valid = 1'b0; sym_last = 1'b0; ds_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_syn_out", syn_out, c_zero);
    check("rst_syn_valid", {127'd0, syn_valid}, 128'd0);
    check("rst_nonzero", {127'd0, syn_nonzero}, 128'd0);
    check("rst_frame_err", {127'd0, frame_err}, 128'd0);
    check("rst_ready", {127'd0, sym_ready}, 128'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // All-zero codeword.
    send_cw(-1, 8'h00, -1, 8'h00);
    expect_result("zero", c_zero, 1'b0);

    // Only the degree-0 symbol set.
    send_cw(N - 1, 8'h05, -1, 8'h00);
    expect_result("deg0", c_deg0, 1'b1);

    // Only the degree-1 symbol set.
    send_cw(N - 2, 8'h01, -1, 8'h00);
    expect_result("deg1", c_deg1, 1'b1);

    // Downstream busy for 20 cycles after the final symbol.
    ds_busy = 1'b1;
    send_cw(N - 2, 8'h01, N - 1, 8'h05);
    vc = valid_cnt;
    repeat (20) @(posedge clk);
    #1;
    check("busy_no_valid", {127'd0, syn_valid}, 128'd0);
    @(negedge clk);
    check("busy_hold_cnt", 128'(valid_cnt), 128'(vc));
    @(posedge clk); #1;
    ds_busy = 1'b0;
    check("busy_valid_early", {127'd0, syn_valid}, 128'd0);
    @(posedge clk); #1;
    check("busy_valid", {127'd0, syn_valid}, 128'd1);
    check("busy_syn", syn_out, c_d1d0);
    @(posedge clk); #1;

    // Result pending while the next codeword streams in and stalls on its last symbol.
    ds_busy = 1'b1;
    send_cw(N - 1, 8'h05, -1, 8'h00);
    for (int i = 0; i < N - 1; i++) begin
      send_sym((i == N - 3) ? 8'h01 : 8'h00, 1'b0);
    end
    vc = valid_cnt;
    sym_in = 8'h00; sym_valid = 1'b1; sym_last = 1'b1;
    @(negedge clk);
    check("stall_ready_low", {127'd0, sym_ready}, 128'd0);
    repeat (3) @(negedge clk);
    check("stall_ready_held", {127'd0, sym_ready}, 128'd0);
    check("stall_syn_kept", syn_out, c_deg0);
    check("stall_no_valid", 128'(valid_cnt), 128'(vc));
    ds_busy = 1'b0;
    @(posedge clk); #1;
    check("stall_first_valid", {127'd0, syn_valid}, 128'd1);
    check("stall_first_syn", syn_out, c_deg0);
    check("stall_ready_back", {127'd0, sym_ready}, 128'd1);
    @(posedge clk); #1;
    sym_valid = 1'b0; sym_last = 1'b0;
    check("stall_pulse_end", {127'd0, syn_valid}, 128'd0);
    check("stall_second_load", syn_out, c_deg2);
    @(posedge clk); #1;
    check("stall_second_valid", {127'd0, syn_valid}, 128'd1);
    check("stall_second_syn", syn_out, c_deg2);
    @(posedge clk); #1;

    // Early sym_last.
    vc = valid_cnt;
    for (int i = 0; i <= 100; i++) begin
      send_sym(8'h11, i == 100);
    end
    check("early_ferr", {127'd0, frame_err}, 128'd1);
    check("early_syn_kept", syn_out, c_deg2);
    @(posedge clk); #1;
    check("early_ferr_pulse", {127'd0, frame_err}, 128'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("early_no_valid", 128'(valid_cnt), 128'(vc));
    @(posedge clk); #1;

    // Missing sym_last on the final index.
    for (int i = 0; i < N; i++) begin
      send_sym(8'h22, 1'b0);
    end
    check("nolast_ferr", {127'd0, frame_err}, 128'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("nolast_no_valid", 128'(valid_cnt), 128'(vc));
    check("nolast_syn_kept", syn_out, c_deg2);
    @(posedge clk); #1;

    send_cw(N - 1, 8'h05, -1, 8'h00);
    expect_result("after_ferr", c_deg0, 1'b1);

    // Reset in the middle of a frame.
    for (int i = 0; i < 150; i++) begin
      send_sym(8'h5A, 1'b0);
    end
    rst = 1'b1;
    #1;
    check("mrst_syn_out", syn_out, c_zero);
    check("mrst_nonzero", {127'd0, syn_nonzero}, 128'd0);
    check("mrst_valid", {127'd0, syn_valid}, 128'd0);
    check("mrst_ready", {127'd0, sym_ready}, 128'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vc = valid_cnt;
    @(posedge clk); #1;
    send_cw(N - 3, 8'h01, -1, 8'h00);
    expect_result("post_rst", c_deg2, 1'b1);
    @(negedge clk);
    check("post_rst_one_valid", 128'(valid_cnt), 128'(vc + 1));

    check("total_valid", 128'(valid_cnt), 128'd8);
    check("total_ferr", 128'(ferr_cnt), 128'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rs_syndrome_calc.md
# rs_syndrome_calc

Computes the 16 GF(2^8) Reed-Solomon syndromes of a received codeword, one symbol per clock. It is the producer end of the `BerlekampMassey` 128-bit syndrome interface: its packed `syn_out` / `syn_valid` pair drives `data_in` / `valid_in`, and it honours that block's `busy`. It holds one finished result while it accumulates the next codeword.

## Interface
- `N_SYM`, default 255: codeword length in symbols. Legal range 17..255.
- `clk`  in  1: clock. All logic is on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `sym_in`  in  8: received symbol. Highest-degree coefficient first.
- `sym_valid`  in  1: `sym_in` is valid. A symbol is accepted when `sym_valid && sym_ready`.
- `sym_last`  in  1: marks the final symbol of the codeword. Qualified by acceptance.
- `sym_ready`  out  1: the block can accept a symbol.
- `ds_busy`  in  1: downstream decoder busy. Connect to `BerlekampMassey.busy`.
- `syn_out`  out  128: packed syndromes. `syn_out[8k+7:8k]` = S_(k+1), k=0..15.
- `syn_valid`  out  1: one-cycle pulse. `syn_out` is valid for the decoder.
- `syn_nonzero`  out  1: OR of all syndrome bits. Meaning: errors are present. Valid alongside `syn_out`.
- `frame_err`  out  1: one-cycle pulse. `sym_last` did not coincide with symbol index `N_SYM-1`.

## Operation
- Field: GF(2^8), primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), alpha = 0x02. Roots alpha^1..alpha^16, so fcr = 1.
- Storage:
  - 16 accumulators `acc[j]`, 8 bits each.
  - Symbol counter `cnt`, 0..N_SYM-1.
  - Output register `syn_out` and flag `pending`.
- On each accepted symbol, Horner update for all j=1..16 in parallel:
  - If `cnt==0`: `acc[j] <= sym_in`.
  - Otherwise: `acc[j] <= acc[j]*alpha^j ^ sym_in`.
  - Constant multipliers are pure XOR networks. No tables.
- Non-final accepted symbol (`cnt < N_SYM-1`): `cnt <= cnt+1`.
- Final symbol (`cnt == N_SYM-1`):
  - Load the updated values (including this symbol) into `syn_out`.
  - Set `syn_nonzero` from the loaded value.
  - Set `pending <= 1` and `cnt <= 0`.
- Length checking:
  - `sym_last` accepted with `cnt != N_SYM-1`: pulse `frame_err`, discard the frame (`cnt <= 0`), leave `syn_out` unchanged.
  - Symbol `cnt == N_SYM-1` accepted without `sym_last`: pulse `frame_err` and discard the frame the same way.
- `sym_ready = !(pending && cnt == N_SYM-1)`. The next codeword may stream in while a result is pending, but stalls on its last symbol.
- Output handshake:
  - When `pending && !ds_busy && !syn_valid`: `syn_valid <= 1` and `pending <= 0`.
  - `syn_valid` is high for exactly one cycle.
  - `syn_out` holds until the next final-symbol load.
- State summary: {IDLE: `cnt==0`, `!pending`} → ACCUM → (final) PENDING → (downstream free) EMIT. ACCUM and PENDING may coexist.
- Reset mid-frame: partial accumulation is lost and no `syn_valid` is produced for that frame.

## Timing
- Reset values: `syn_out`=0, `syn_valid`=0, `syn_nonzero`=0, `frame_err`=0, `cnt`=0, `pending`=0, all `acc`=0. `sym_ready` is 1 immediately after reset.
- Throughput: one symbol per cycle. A back-to-back codeword costs N_SYM cycles.
- Latency: final symbol accepted at edge t → `syn_out` updated after t → `syn_valid` high after edge t+1 if `ds_busy`=0 at t+1.
- While `ds_busy` is high, `syn_valid` is deferred. It rises after the first edge at which `ds_busy` is sampled low.
- `frame_err` is registered: high during the cycle after the offending acceptance.
- Final symbol accepted while `pending` is clear and `syn_valid` is high: legal. `syn_out` changes after the pulse ends.
- No combinational path from `sym_valid` to `sym_ready`.

## Test plan
- All-zero codeword, N_SYM=255, `ds_busy`=0 → `syn_valid` pulse 2 cycles after the last symbol; `syn_out`=128'h0; `syn_nonzero`=0.
- Zero codeword except final (degree-0) symbol = 0x05 → `syn_out`=128'h0505…05 (16 bytes); `syn_nonzero`=1.
- Zero codeword except degree-1 symbol (index 253) = 0x01 → `syn_out`=128'h4C26_1387_CDE8_743A_1D80_4020_1008_0402.
- Hold `ds_busy`=1 for 20 cycles after the first codeword and stream a second codeword immediately:
  - First `syn_valid` appears 1 cycle after `ds_busy` falls.
  - `sym_ready` drops at the second codeword's index 254.
  - No result is lost or overwritten.
- `sym_last` at index 100 → `frame_err` pulse; no `syn_valid`. The next full codeword decodes correctly.
- Assert `rst` at index 150, release, then send a full codeword → outputs at their reset values during reset. Only the post-reset codeword produces `syn_valid`, with correct syndromes.
